// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, FSM state encoding and status flag encodings
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b1111;
  localparam logic [1:0] FLAG_OK   = 2'b00;
  localparam logic [1:0] FLAG_DIV0 = 2'b01;
  localparam logic [1:0] FLAG_ILL  = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  function automatic logic is_single(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLL, OP_SRL};
  endfunction
endpackage

// File: rtl/alu_if.sv
// alu_if: request/status bundle between the ALU control stage (master) and alu_core (slave)
interface alu_if #(parameter int DATA_W = 32);
  logic [3:0] ALU_control;
  logic [DATA_W-1:0] A, B, result, remainder;
  logic [4:0] shamt;
  logic start, ready, busy, done, zero;
  logic [1:0] flag;
  modport master (output ALU_control, A, B, shamt, start,
                  input ready, busy, done, result, remainder, zero, flag);
  modport slave (input ALU_control, A, B, shamt, start,
                 output ready, busy, done, result, remainder, zero, flag);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiplier and (with ALU_DIV_EN) signed restoring divider, one bit per cycle
module alu_muldiv #(parameter int DATA_W = 32) (
  input logic clk,
  input logic reset,
  input logic load,
`ifdef ALU_DIV_EN
  input logic is_div,
`endif
  input logic [DATA_W-1:0] a,
  input logic [DATA_W-1:0] b,
  output logic last,
  output logic [DATA_W-1:0] res,
  output logic [DATA_W-1:0] rem
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] acc, mcand, mplier, acc_n;
  assign last = cnt == CW'(DATA_W - 1);
  assign acc_n = mplier[0] ? acc + mcand : acc;
  // Low product bits are sign-agnostic, so a plain shift-add over the two's complement operands suffices
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
      mcand <= a;
      mplier <= b;
    end else begin
      cnt <= cnt + CW'(1);
      acc <= acc_n;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end
`ifdef ALU_DIV_EN
  logic [DATA_W-1:0] dvd, dvs, rq, dvd_n, rq_n;
  logic [DATA_W:0] r_sh, diff;
  logic neg_q, neg_r, div_q;
  assign r_sh = {rq, dvd[DATA_W-1]};
  assign diff = r_sh - {1'b0, dvs};
  assign dvd_n = {dvd[DATA_W-2:0], ~diff[DATA_W]};
  assign rq_n = diff[DATA_W] ? r_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  // Divide magnitudes; signs are reapplied on the way out (quotient toward zero, remainder follows A)
  always_ff @(posedge clk)
    if (reset) begin
      dvd <= '0;
      dvs <= '0;
      rq <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_q <= 1'b0;
    end else if (load) begin
      dvd <= a[DATA_W-1] ? -a : a;
      dvs <= b[DATA_W-1] ? -b : b;
      rq <= '0;
      neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
      neg_r <= a[DATA_W-1];
      div_q <= is_div;
    end else begin
      dvd <= dvd_n;
      rq <= rq_n;
    end
  assign res = div_q ? (neg_q ? -dvd_n : dvd_n) : acc_n;
  assign rem = div_q ? (neg_r ? -rq_n : rq_n) : '0;
`else
  assign res = acc_n;
  assign rem = '0;
`endif
endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU with single-cycle ops and iterative mul (div when ALU_DIV_EN is defined)
module alu_core import alu_pkg::*; #(parameter int DATA_W = 32) (
  input logic clk,
  input logic reset,
  alu_if.slave bus
);
  state_t state, state_n;
  logic [DATA_W-1:0] result_q, result_n, rem_q, rem_n, alu_y, md_res, md_rem;
  logic [1:0] flag_q, flag_n;
  logic accept, load, md_last;
  assign bus.ready = state == S_IDLE || state == S_DONE;
  assign bus.busy = state == S_MUL || state == S_DIV;
  assign bus.done = state == S_DONE;
  assign bus.result = result_q;
  assign bus.remainder = rem_q;
  assign bus.zero = result_q == '0;
  assign bus.flag = flag_q;
  assign accept = bus.start && bus.ready;
  alu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk(clk),
    .reset(reset),
    .load(load),
`ifdef ALU_DIV_EN
    .is_div(bus.ALU_control == OP_DIV),
`endif
    .a(bus.A),
    .b(bus.B),
    .last(md_last),
    .res(md_res),
    .rem(md_rem)
  );
  // Single-cycle operations; unknown codes yield zero
  always_comb begin
    alu_y = '0;
    case (bus.ALU_control)
      OP_AND: alu_y = bus.A & bus.B;
      OP_OR: alu_y = bus.A | bus.B;
      OP_ADD: alu_y = bus.A + bus.B;
      OP_SUB: alu_y = bus.A - bus.B;
      OP_SLT: alu_y = DATA_W'($signed(bus.A) < $signed(bus.B));
      OP_NOR: alu_y = ~(bus.A | bus.B);
      OP_SLL: alu_y = bus.B << bus.shamt;
      OP_SRL: alu_y = bus.B >> bus.shamt;
      default: alu_y = '0;
    endcase
  end
  // Next state and next output values; outputs hold until the next completion
  always_comb begin
    state_n = state;
    result_n = result_q;
    rem_n = rem_q;
    flag_n = flag_q;
    load = 1'b0;
    if (accept) begin
      if (bus.ALU_control == OP_MUL) begin
        state_n = S_MUL;
        load = 1'b1;
      end
`ifdef ALU_DIV_EN
      else if (bus.ALU_control == OP_DIV && bus.B == '0) begin
        state_n = S_DONE;
        result_n = '1;
        rem_n = bus.A;
        flag_n = FLAG_DIV0;
      end else if (bus.ALU_control == OP_DIV) begin
        state_n = S_DIV;
        load = 1'b1;
      end
`endif
      else begin
        state_n = S_DONE;
        result_n = alu_y;
        rem_n = '0;
        flag_n = is_single(bus.ALU_control) ? FLAG_OK : FLAG_ILL;
      end
    end else if (state == S_DONE) begin
      state_n = S_IDLE;
    end else if (state != S_IDLE && md_last) begin
      state_n = S_DONE;
      result_n = md_res;
      rem_n = md_rem;
      flag_n = FLAG_OK;
    end
  end
  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      result_q <= '0;
      rem_q <= '0;
      flag_q <= FLAG_OK;
    end else begin
      state <= state_n;
      result_q <= result_n;
      rem_q <= rem_n;
      flag_q <= flag_n;
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against an arithmetic reference model
module tb_alu_core;
  logic clk = 1'b0;
  logic reset;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_if #(.DATA_W(32)) bus ();
  alu_core #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic [31:0] rm,
                                output logic [1:0] f, output int lat);
    longint p;
    int q;
    r = 0; rm = 0; f = 2'b00; lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1110: r = b << sh;
      4'b1111: r = b >> sh;
      4'b0011: begin
        p = longint'($signed(a)) * longint'($signed(b));
        r = p[31:0];
        lat = 33;
      end
`ifdef ALU_DIV_EN
      4'b0100: begin
        if (b == 0) begin
          r = 32'hffffffff; rm = a; f = 2'b01;
        end else if (a == 32'h80000000 && b == 32'hffffffff) begin
          r = a; rm = 0; lat = 33;
        end else begin
          q = $signed(a) / $signed(b);
          r = q;
          q = $signed(a) % $signed(b);
          rm = q;
          lat = 33;
        end
      end
`endif
      default: f = 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffffffff;
      3: return 32'h80000000;
      4: return 32'h7fffffff;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit poke, output int cyc, output int nbusy);
    bus.ALU_control = op; bus.A = a; bus.B = b; bus.shamt = sh; bus.start = 1'b1;
    cyc = 0; nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy) nbusy++;
      bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ALU_control = 4'($urandom); bus.A = $urandom; bus.B = $urandom; bus.shamt = 5'($urandom);
    end while (!bus.done && cyc < 200);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b want 1", bus.ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h want 0", bus.result); end
    n_tests++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL reset remainder: got %h want 0", bus.remainder); end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset zero: got %b want 1", bus.zero); end
    n_tests++; if (bus.flag !== 2'b00) begin n_fail++; $display("FAIL reset flag: got %b want 00", bus.flag); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL idle done: got %b want 0", bus.done); end
  endtask

  task automatic test_add_boundary;
    int cyc, nb;
    @(negedge clk);
    issue(4'b0010, 32'h7fffffff, 32'h1, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'h80000000) begin n_fail++; $display("FAIL add_wrap result: got %h want 80000000", bus.result); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL add_wrap latency: got %0d want 1", cyc); end
    n_tests++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL add_wrap zero: got %b want 0", bus.zero); end
    n_tests++; if (bus.flag !== 2'b00) begin n_fail++; $display("FAIL add_wrap flag: got %b want 00", bus.flag); end
  endtask

  task automatic test_sub_slt;
    int cyc, nb;
    @(negedge clk);
    issue(4'b0110, 32'd5, 32'd5, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL sub result: got %h want 0", bus.result); end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL sub zero: got %b want 1", bus.zero); end
    @(negedge clk);
    issue(4'b0111, 32'hffffffff, 32'd1, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL slt result: got %h want 1", bus.result); end
    n_tests++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL slt zero: got %b want 0", bus.zero); end
  endtask

  task automatic test_mul;
    int cyc, nb;
    @(negedge clk);
    issue(4'b0011, 32'hfffffffd, 32'd7, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'hffffffeb) begin n_fail++; $display("FAIL mul result: got %h want ffffffeb", bus.result); end
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL mul latency: got %0d want 33", cyc); end
    n_tests++; if (nb !== 32) begin n_fail++; $display("FAIL mul busy cycles: got %0d want 32", nb); end
    n_tests++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL mul remainder: got %h want 0", bus.remainder); end
  endtask

  task automatic test_div;
    int cyc, nb;
    @(negedge clk);
`ifdef ALU_DIV_EN
    issue(4'b0100, 32'hfffffff9, 32'd2, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'hfffffffd) begin n_fail++; $display("FAIL div result: got %h want fffffffd", bus.result); end
    n_tests++; if (bus.remainder !== 32'hffffffff) begin n_fail++; $display("FAIL div remainder: got %h want ffffffff", bus.remainder); end
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div latency: got %0d want 33", cyc); end
    @(negedge clk);
    issue(4'b0100, 32'd9, 32'd0, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'hffffffff) begin n_fail++; $display("FAIL div0 result: got %h want ffffffff", bus.result); end
    n_tests++; if (bus.remainder !== 32'd9) begin n_fail++; $display("FAIL div0 remainder: got %h want 9", bus.remainder); end
    n_tests++; if (bus.flag !== 2'b01) begin n_fail++; $display("FAIL div0 flag: got %b want 01", bus.flag); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL div0 latency: got %0d want 1", cyc); end
    @(negedge clk);
    issue(4'b0100, 32'h80000000, 32'hffffffff, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'h80000000) begin n_fail++; $display("FAIL divmin result: got %h want 80000000", bus.result); end
    n_tests++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL divmin remainder: got %h want 0", bus.remainder); end
    n_tests++; if (bus.flag !== 2'b00) begin n_fail++; $display("FAIL divmin flag: got %b want 00", bus.flag); end
`else
    issue(4'b0100, 32'hfffffff9, 32'd2, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.flag !== 2'b10) begin n_fail++; $display("FAIL nodiv flag: got %b want 10", bus.flag); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL nodiv result: got %h want 0", bus.result); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL nodiv latency: got %0d want 1", cyc); end
`endif
  endtask

  task automatic test_illegal;
    int cyc, nb;
    @(negedge clk);
    issue(4'b0010, 32'd3, 32'd4, 5'd0, 1'b0, cyc, nb);
    @(negedge clk);
    issue(4'b0101, 32'd3, 32'd4, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.flag !== 2'b10) begin n_fail++; $display("FAIL illegal flag: got %b want 10", bus.flag); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL illegal result: got %h want 0", bus.result); end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL illegal zero: got %b want 1", bus.zero); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL illegal latency: got %0d want 1", cyc); end
  endtask

  task automatic test_busy_ignore;
    int cyc, nb;
    @(negedge clk);
    issue(4'b0011, 32'd6, 32'd7, 5'd0, 1'b1, cyc, nb);
    n_tests++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL busy_ignore result: got %h want 2a", bus.result); end
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL busy_ignore latency: got %0d want 33", cyc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (bus.done !== 1'b0 || bus.result !== 32'd42) begin n_fail++; $display("FAIL hold: done %b result %h want 0 2a", bus.done, bus.result); end
    end
  endtask

  task automatic test_reset_mid_mul;
    int dones = 0;
    @(negedge clk);
    bus.ALU_control = 4'b0011; bus.A = 32'd1000; bus.B = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_mul busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL abort ready: got %b want 1", bus.ready); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort result: got %h want 0", bus.result); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", bus.busy); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL abort done count: got %0d want 0", dones); end
    reset = 1'b1;
    bus.ALU_control = 4'b0010; bus.A = 32'd1; bus.B = 32'd1; bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    n_tests++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin n_fail++; $display("FAIL start_in_reset: done %b ready %b want 0 1", bus.done, bus.ready); end
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0 || bus.result !== 32'h0) begin n_fail++; $display("FAIL start_in_reset after: done %b result %h want 0 0", bus.done, bus.result); end
  endtask

  task automatic test_back_to_back;
    int cyc, nb;
    @(negedge clk);
    issue(4'b0010, 32'd10, 32'd20, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'd30 || cyc !== 1) begin n_fail++; $display("FAIL b2b first: result %h cyc %0d want 1e 1", bus.result, cyc); end
    issue(4'b0011, 32'hfffffffe, 32'd5, 5'd0, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'hfffffff6 || cyc !== 33) begin n_fail++; $display("FAIL b2b mul: result %h cyc %0d want fffffff6 33", bus.result, cyc); end
    issue(4'b1110, 32'd0, 32'd3, 5'd4, 1'b0, cyc, nb);
    n_tests++; if (bus.result !== 32'd48 || cyc !== 1) begin n_fail++; $display("FAIL b2b sll: result %h cyc %0d want 30 1", bus.result, cyc); end
  endtask

  task automatic test_random;
    int cyc, nb, lat;
    logic [3:0] op;
    logic [31:0] a, b, er, erm;
    logic [4:0] sh;
    logic [1:0] ef;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom); a = pick(); b = pick(); sh = 5'($urandom);
      model(op, a, b, sh, er, erm, ef, lat);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(op, a, b, sh, 1'b0, cyc, nb);
      n_tests++; if (bus.result !== er) begin n_fail++; $display("FAIL rand[%0d] op %b a %h b %h sh %0d result: got %h want %h", i, op, a, b, sh, bus.result, er); end
      n_tests++; if (bus.remainder !== erm) begin n_fail++; $display("FAIL rand[%0d] op %b remainder: got %h want %h", i, op, bus.remainder, erm); end
      n_tests++; if (bus.flag !== ef) begin n_fail++; $display("FAIL rand[%0d] op %b flag: got %b want %b", i, op, bus.flag, ef); end
      n_tests++; if (bus.zero !== (er == 0)) begin n_fail++; $display("FAIL rand[%0d] op %b zero: got %b want %b", i, op, bus.zero, er == 0); end
      n_tests++; if (cyc !== lat) begin n_fail++; $display("FAIL rand[%0d] op %b latency: got %0d want %0d", i, op, cyc, lat); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.ALU_control = 4'b0; bus.A = '0; bus.B = '0; bus.shamt = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_add_boundary;
    test_sub_slt;
    test_mul;
    test_div;
    test_illegal;
    test_busy_ignore;
    test_reset_mid_mul;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port ALU_control, input, 4, operation code from ALU control stage.
REQ-005 SHALL have port A, input, DATA_W, operand rs.
REQ-006 SHALL have port B, input, DATA_W, operand rt.
REQ-007 SHALL have port shamt, input, 5, shift amount.
REQ-008 SHALL have port start, input, 1, request; accepted only when ready=1.
REQ-009 SHALL have port ready, output, 1, can accept start this cycle.
REQ-010 SHALL have port busy, output, 1, multi-cycle mul/div in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse; result valid.
REQ-012 SHALL have port result, output, DATA_W, registered result.
REQ-013 SHALL have port remainder, output, DATA_W, div remainder, else 0.
REQ-014 SHALL have port zero, output, 1, result==0, registered with result.
REQ-015 SHALL have port flag, output, 2, 00 ok, 01 div-by-zero, 10 illegal code.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE; ready=1 in IDLE or DONE, busy=1 in MUL or DIV.
REQ-017 SHALL, on accepted start with 0000 and/0001 or/0010 add/0110 sub/0111 slt (signed)/1100 nor/1110 sll (B<<shamt)/1111 srl (B>>shamt, logical), go to DONE next edge; done one cycle after start.
REQ-018 SHALL wrap add/sub modulo 2^DATA_W; no overflow flag.
REQ-019 SHALL, for 0011 mul, do signed shift-add, one bit per cycle, DATA_W iterations, result = low DATA_W product bits; done DATA_W+1 cycles after start.
REQ-020 SHALL, for 0100 div, do signed restoring division, DATA_W iterations, quotient truncated toward zero, remainder sign = sign of A; done DATA_W+1 cycles after start.
REQ-021 SHALL, for div with B==0, skip iteration: done next cycle, result all-ones, remainder=A, flag=01.
REQ-022 SHALL, for div of most-negative by -1, return result=most-negative, remainder=0, flag=00.
REQ-023 SHALL treat any other code as illegal: done next cycle, result=0, zero=1, flag=10.
REQ-024 SHALL latch A, B, shamt, ALU_control at acceptance; input changes while busy are ignored.
REQ-025 SHALL ignore start while busy; no queueing.
REQ-026 SHALL allow start in DONE (back-to-back); done then reasserts per new op latency.
REQ-027 SHALL hold result, remainder, zero, flag from done until next done.

Reset
REQ-028 SHALL, with reset=1 at any edge, including mid-MUL/DIV, abort, enter IDLE, clear result, remainder, flag, done, busy to 0, set zero=1, ready=1.
REQ-029 SHALL ignore start in the same edge as reset.

Configuration
REQ-030 SHALL with ALU_DIV_EN defined include the divider and REQ-020..022.
REQ-031 SHALL without ALU_DIV_EN treat 0100 as illegal per REQ-023 and instantiate no divider logic.

Structure
REQ-032 SHALL take ALU_control code constants, FSM state encoding, flag encodings from shared package alu_pkg, reused by the ALU control stage.
REQ-033 SHALL place iterative mul/div datapath (accumulator, counter, sign fix-up) in sub-module alu_muldiv; top holds FSM, single-cycle ops, output registers.

Verification
REQ-034 SHALL test add 0x7FFFFFFF+1 -> result 0x80000000, done 1 cycle later, zero=0.
REQ-035 SHALL test sub 5-5 -> result 0, zero=1; slt -1<1 -> result 1.
REQ-036 SHALL test mul -3*7 -> result 0xFFFFFFEB, done 33 cycles after start, busy 32 cycles.
REQ-037 SHALL test div -7/2 -> result 0xFFFFFFFD, remainder 0xFFFFFFFF; div 9/0 -> result 0xFFFFFFFF, remainder 9, flag 01.
REQ-038 SHALL test reset at cycle 10 of mul -> next cycle ready=1, result 0, no done.
REQ-039 SHALL test code 0101 -> flag 10, result 0; start while busy -> ignored, first op result unchanged.
